// File: rtl/multi_ch_test_frame_gen.sv
// rtl/multi_ch_test_frame_gen.sv - multi-channel test-frame source with header, incrementing payload and backpressure
module multi_ch_test_frame_gen #(
  parameter int         NUM_CH   = 4,
  parameter int         MAX_LEN  = 2048,
  parameter logic [7:0] SYNC     = 8'hBB,
  parameter int         PERIOD_W = 32
) (
  input  logic                sys_clk_i,
  input  logic                rst_i,
  input  logic [NUM_CH-1:0]   ch_en_i,
  input  logic                rr_mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [15:0]         frame_len_i,
  input  logic [7:0]          dangwei_i,
  output logic [7:0]          dout_o,
  output logic                dout_valid_o,
  input  logic                dout_ready_i,
  output logic                dout_sof_o,
  output logic                dout_eof_o,
  output logic [3:0]          cur_ch_o,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic                trigger;
  logic [3:0]          ptr;
  logic [3:0]          sel;
  logic [3:0]          idx;
  logic                any_en;
  logic [15:0]         en_ext;
  logic [15:0]         len;
  logic [15:0]         len_c;
  logic [15:0]         k;
  logic [15:0]         k_nxt;
  logic [15:0]         cur_seq;
  logic [15:0]         seq [16];
  logic [7:0]          dw;
  logic [7:0]          nxt_byte;
  logic [7:0]          hdr_xor;

  assign trigger   = (cnt == period_i);
  assign overrun_o = trigger && busy_o;
  assign en_ext    = 16'(ch_en_i);
  assign k_nxt     = k + 16'd1;

  // Scan order is arranged so the last hit wins: the first enabled channel after
  // the pointer in round-robin mode, the lowest enabled index otherwise.
  always_comb begin
    sel    = '0;
    any_en = 1'b0;
    idx    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = rr_mode_i ? 4'((int'(ptr) + i) % NUM_CH) : 4'(i - 1);
      if (en_ext[idx]) begin
        sel    = idx;
        any_en = 1'b1;
      end
    end
  end

  always_comb begin
    len_c = frame_len_i;
    if (frame_len_i < 16'd16)
      len_c = 16'd16;
    else if (frame_len_i > MAX_L)
      len_c = MAX_L;
  end

  always_comb begin
    hdr_xor = SYNC ^ {4'h0, cur_ch_o} ^ len[15:8] ^ len[7:0] ^ cur_seq[15:8] ^ cur_seq[7:0] ^ dw;
    case (k_nxt)
      16'd1:   nxt_byte = {4'h0, cur_ch_o};
      16'd2:   nxt_byte = len[15:8];
      16'd3:   nxt_byte = len[7:0];
      16'd4:   nxt_byte = cur_seq[15:8];
      16'd5:   nxt_byte = cur_seq[7:0];
      16'd6:   nxt_byte = dw;
      16'd7:   nxt_byte = hdr_xor;
      default: nxt_byte = k_nxt[7:0] - 8'd8 + {4'h0, cur_ch_o};
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= 4'(NUM_CH - 1);
      len          <= '0;
      k            <= '0;
      cur_seq      <= '0;
      dw           <= '0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      dout_sof_o   <= 1'b0;
      dout_eof_o   <= 1'b0;
      cur_ch_o     <= '0;
      busy_o       <= 1'b0;
      for (int i = 0; i < 16; i++) seq[i] <= '0;
    end else begin
      // >= keeps the counter bounded if period_i is lowered below the current count
      cnt <= (cnt >= period_i) ? '0 : cnt + PERIOD_W'(1);
      case (state)
        IDLE: begin
          if (trigger && any_en) begin
            state        <= HDR;
            cur_ch_o     <= sel;
            ptr          <= sel;
            len          <= len_c;
            cur_seq      <= seq[sel];
            dw           <= dangwei_i;
            k            <= '0;
            dout_o       <= SYNC;
            dout_valid_o <= 1'b1;
            dout_sof_o   <= 1'b1;
            dout_eof_o   <= 1'b0;
            busy_o       <= 1'b1;
          end
        end
        default: begin
          if (dout_valid_o && dout_ready_i) begin
            if (dout_eof_o) begin
              state         <= IDLE;
              dout_o        <= '0;
              dout_valid_o  <= 1'b0;
              dout_sof_o    <= 1'b0;
              dout_eof_o    <= 1'b0;
              busy_o        <= 1'b0;
              seq[cur_ch_o] <= cur_seq + 16'd1;
            end else begin
              state      <= (k_nxt >= 16'd8) ? PAY : HDR;
              k          <= k_nxt;
              dout_o     <= nxt_byte;
              dout_sof_o <= 1'b0;
              dout_eof_o <= (k_nxt == len - 16'd1);
            end
          end
        end
      endcase
    end
  end

endmodule
